reservation_station: RTL and testbench

RESERVATION_STATION -- requirements
Module: reservation_station

---
 rtl/tomasulo_pkg.sv | 22 ++
 rtl/reservation_station_if.sv | 36 +++
 rtl/rs_entry.sv | 100 ++++++++++
 rtl/reservation_station.sv | 89 ++++++++
 tb/tb_reservation_station.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/tomasulo_pkg.sv
// Shared widths, opcodes and entry-state encoding for the Tomasulo reservation station.
package tomasulo_pkg;

  localparam int TAG_W  = 3;
  localparam int DATA_W = 16;

  localparam logic [TAG_W-1:0] TAG_NONE = 3'd0;

  localparam logic [3:0] ADD = 4'b0000;
  localparam logic [3:0] SUB = 4'b0001;
  localparam logic [3:0] LD  = 4'b0010;
  localparam logic [3:0] SD  = 4'b0011;
  localparam logic [3:0] MUL = 4'b0100;

  typedef enum logic [1:0] {
    RS_FREE    = 2'd0,
    RS_WAITING = 2'd1,
    RS_READY   = 2'd2,
    RS_EXEC    = 2'd3
  } rs_state_e;

endpackage

// File: rtl/reservation_station_if.sv
// Issue, common-data-bus and functional-unit signals of the reservation station.
interface reservation_station_if;
  import tomasulo_pkg::*;

  logic              issue_valid;
  logic              issue_ready;
  logic [DATA_W-1:0] issue_inst;
  logic [DATA_W-1:0] issue_vj;
  logic [DATA_W-1:0] issue_vk;
  logic [TAG_W-1:0]  issue_qj;
  logic [TAG_W-1:0]  issue_qk;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  logic              uf_available;
  logic              uf_start;
  logic [DATA_W-1:0] uf_inst;
  logic [TAG_W-1:0]  uf_tag;
  logic [DATA_W-1:0] uf_reg1;
  logic [DATA_W-1:0] uf_reg2;
  logic              uf_done;
  logic [TAG_W-1:0]  uf_done_tag;

  modport slave (
    input  issue_valid, issue_inst, issue_vj, issue_vk, issue_qj, issue_qk,
    input  cdb_valid, cdb_tag, cdb_data, uf_available, uf_done, uf_done_tag,
    output issue_ready, uf_start, uf_inst, uf_tag, uf_reg1, uf_reg2
  );

  modport master (
    output issue_valid, issue_inst, issue_vj, issue_vk, issue_qj, issue_qk,
    output cdb_valid, cdb_tag, cdb_data, uf_available, uf_done, uf_done_tag,
    input  issue_ready, uf_start, uf_inst, uf_tag, uf_reg1, uf_reg2
  );

endinterface

// File: rtl/rs_entry.sv
// One reservation-station entry: state, operand values/tags, CDB snoop and ready flag.
// RS_WAKEUP_BYPASS_EN lets an entry dispatch in the same cycle its last operand arrives.
module rs_entry
  import tomasulo_pkg::*;
#(
  parameter int MY_TAG = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_alloc,
  input  logic [DATA_W-1:0] i_inst,
  input  logic [DATA_W-1:0] i_vj,
  input  logic [DATA_W-1:0] i_vk,
  input  logic [TAG_W-1:0]  i_qj,
  input  logic [TAG_W-1:0]  i_qk,
  input  logic              i_cdb_valid,
  input  logic [TAG_W-1:0]  i_cdb_tag,
  input  logic [DATA_W-1:0] i_cdb_data,
  input  logic              i_dispatch,
  input  logic              i_done,
  input  logic [TAG_W-1:0]  i_done_tag,
  output rs_state_e         o_state,
  output logic              o_ready,
  output logic [DATA_W-1:0] o_inst,
  output logic [DATA_W-1:0] o_vj,
  output logic [DATA_W-1:0] o_vk
);

  rs_state_e         r_state;
  logic [DATA_W-1:0] r_inst, r_vj, r_vk;
  logic [TAG_W-1:0]  r_qj, r_qk;

  // Tag 0 never matches because a zero Q means the operand is already held.
  logic w_hit_j, w_hit_k, w_iss_hit_j, w_iss_hit_k, w_wake;
  logic [DATA_W-1:0] w_vj_now, w_vk_now;
  logic [TAG_W-1:0]  w_qj_now, w_qk_now, w_iss_qj, w_iss_qk;

  assign w_hit_j     = i_cdb_valid && (r_qj != TAG_NONE) && (i_cdb_tag == r_qj);
  assign w_hit_k     = i_cdb_valid && (r_qk != TAG_NONE) && (i_cdb_tag == r_qk);
  assign w_iss_hit_j = i_cdb_valid && (i_qj != TAG_NONE) && (i_cdb_tag == i_qj);
  assign w_iss_hit_k = i_cdb_valid && (i_qk != TAG_NONE) && (i_cdb_tag == i_qk);
  assign w_vj_now    = w_hit_j ? i_cdb_data : r_vj;
  assign w_vk_now    = w_hit_k ? i_cdb_data : r_vk;
  assign w_qj_now    = w_hit_j ? TAG_NONE : r_qj;
  assign w_qk_now    = w_hit_k ? TAG_NONE : r_qk;
  assign w_iss_qj    = w_iss_hit_j ? TAG_NONE : i_qj;
  assign w_iss_qk    = w_iss_hit_k ? TAG_NONE : i_qk;
  assign w_wake      = (r_state == RS_WAITING) && (w_qj_now == TAG_NONE) && (w_qk_now == TAG_NONE);

`ifdef RS_WAKEUP_BYPASS_EN
  assign o_ready = (r_state == RS_READY) || w_wake;
`else
  assign o_ready = (r_state == RS_READY);
`endif

  assign o_state = r_state;
  assign o_inst  = r_inst;
  assign o_vj    = w_vj_now;
  assign o_vk    = w_vk_now;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= RS_FREE;
      r_inst  <= '0;
      r_vj    <= '0;
      r_vk    <= '0;
      r_qj    <= TAG_NONE;
      r_qk    <= TAG_NONE;
    end else begin
      case (r_state)
        RS_FREE: begin
          if (i_alloc) begin
            r_inst  <= i_inst;
            r_vj    <= w_iss_hit_j ? i_cdb_data : i_vj;
            r_vk    <= w_iss_hit_k ? i_cdb_data : i_vk;
            r_qj    <= w_iss_qj;
            r_qk    <= w_iss_qk;
            r_state <= ((w_iss_qj == TAG_NONE) && (w_iss_qk == TAG_NONE)) ? RS_READY : RS_WAITING;
          end
        end
        RS_WAITING: begin
          r_vj <= w_vj_now;
          r_vk <= w_vk_now;
          r_qj <= w_qj_now;
          r_qk <= w_qk_now;
          if (i_dispatch)  r_state <= RS_EXEC;
          else if (w_wake) r_state <= RS_READY;
        end
        RS_READY: begin
          if (i_dispatch) r_state <= RS_EXEC;
        end
        RS_EXEC: begin
          if (i_done && (i_done_tag == MY_TAG[TAG_W-1:0])) r_state <= RS_FREE;
        end
        default: r_state <= RS_FREE;
      endcase
    end
  end

endmodule

// File: rtl/reservation_station.sv
// Reservation station: NUM_ENTRIES rs_entry copies plus lowest-index issue and dispatch selection.
// Optional RS_WAKEUP_BYPASS_EN (handled in rs_entry) forwards CDB wakeups straight to dispatch.
module reservation_station
  import tomasulo_pkg::*;
#(
  parameter int NUM_ENTRIES = 3,
  parameter int TAG_BASE    = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  reservation_station_if.slave  rs
);

  localparam int IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;

  rs_state_e               w_state [NUM_ENTRIES];
  logic [DATA_W-1:0]       w_inst  [NUM_ENTRIES];
  logic [DATA_W-1:0]       w_vj    [NUM_ENTRIES];
  logic [DATA_W-1:0]       w_vk    [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0]  w_ready, w_alloc, w_dispatch;
  logic                    w_any_free, w_found, w_start;
  logic [IDX_W-1:0]        w_sel;
  logic                    r_last_start;

  always_comb begin
    w_alloc    = '0;
    w_any_free = 1'b0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if ((w_state[i] == RS_FREE) && !w_any_free) begin
        w_alloc[i] = rs.issue_valid;
        w_any_free = 1'b1;
      end
    end
  end

  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (w_ready[i] && !w_found) begin
        w_found = 1'b1;
        w_sel   = IDX_W'(i);
      end
    end
  end

  // Back-to-back starts are blocked so the unit sees one-cycle pulses only.
  assign w_start = rs.uf_available && !r_last_start && w_found && !reset;

  generate
    for (genvar gi = 0; gi < NUM_ENTRIES; gi++) begin : g_entry
      assign w_dispatch[gi] = w_start && (w_sel == IDX_W'(gi));
      rs_entry #(.MY_TAG(TAG_BASE + gi)) u_entry (
        .clock       (clock),
        .reset       (reset),
        .i_alloc     (w_alloc[gi]),
        .i_inst      (rs.issue_inst),
        .i_vj        (rs.issue_vj),
        .i_vk        (rs.issue_vk),
        .i_qj        (rs.issue_qj),
        .i_qk        (rs.issue_qk),
        .i_cdb_valid (rs.cdb_valid),
        .i_cdb_tag   (rs.cdb_tag),
        .i_cdb_data  (rs.cdb_data),
        .i_dispatch  (w_dispatch[gi]),
        .i_done      (rs.uf_done),
        .i_done_tag  (rs.uf_done_tag),
        .o_state     (w_state[gi]),
        .o_ready     (w_ready[gi]),
        .o_inst      (w_inst[gi]),
        .o_vj        (w_vj[gi]),
        .o_vk        (w_vk[gi])
      );
    end
  endgenerate

  assign rs.issue_ready = w_any_free;
  assign rs.uf_start    = w_start;
  assign rs.uf_inst     = w_start ? w_inst[w_sel] : '0;
  assign rs.uf_reg1     = w_start ? w_vk[w_sel]   : '0;
  assign rs.uf_reg2     = w_start ? w_vj[w_sel]   : '0;
  assign rs.uf_tag      = w_start ? (TAG_W'(TAG_BASE) + TAG_W'(w_sel)) : TAG_NONE;

  always_ff @(posedge clock) begin
    if (reset) r_last_start <= 1'b0;
    else       r_last_start <= w_start;
  end

endmodule

// File: tb/tb_reservation_station.sv
// Directed self-checking bench for reservation_station (3 entries, tags 1..3).
module tb_reservation_station;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clock = ~clock;

  reservation_station_if rs_if ();

  reservation_station #(.NUM_ENTRIES(3), .TAG_BASE(1)) dut (
    .clock (clock),
    .reset (reset),
    .rs    (rs_if)
  );

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic probe();
    #3;
  endtask

  task automatic check(input string name, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic issue(input logic [15:0] inst, input logic [15:0] vj, input logic [15:0] vk,
                       input logic [2:0] qj, input logic [2:0] qk);
    rs_if.issue_valid = 1'b1;
    rs_if.issue_inst  = inst;
    rs_if.issue_vj    = vj;
    rs_if.issue_vk    = vk;
    rs_if.issue_qj    = qj;
    rs_if.issue_qk    = qk;
  endtask

  task automatic check_dispatch(input string name, input logic [2:0] tag,
                                input logic [15:0] reg2, input logic [15:0] reg1);
    check({name, "_start"}, {15'd0, rs_if.uf_start}, 16'd1);
    check({name, "_tag"},   {13'd0, rs_if.uf_tag},   {13'd0, tag});
    check({name, "_reg2"},  rs_if.uf_reg2, reg2);
    check({name, "_reg1"},  rs_if.uf_reg1, reg1);
  endtask

  initial begin
    rs_if.issue_valid  = 1'b0;
    rs_if.issue_inst   = '0;
    rs_if.issue_vj     = '0;
    rs_if.issue_vk     = '0;
    rs_if.issue_qj     = '0;
    rs_if.issue_qk     = '0;
    rs_if.cdb_valid    = 1'b0;
    rs_if.cdb_tag      = '0;
    rs_if.cdb_data     = '0;
    rs_if.uf_available = 1'b0;
    rs_if.uf_done      = 1'b0;
    rs_if.uf_done_tag  = '0;

    // Reset state
    next_cycle(); next_cycle();
    reset = 1'b0;
    probe();
    $display("step reset");
    check("rst_issue_ready", {15'd0, rs_if.issue_ready}, 16'd1);
    check("rst_uf_start",    {15'd0, rs_if.uf_start},    16'd0);
    check("rst_uf_inst",     rs_if.uf_inst, 16'd0);

    // ADD with both operands valid: start one cycle after issue
    next_cycle();
    issue(16'h1230, 16'd5, 16'd3, 3'd0, 3'd0);
    rs_if.uf_available = 1'b1;
    probe();
    $display("step add_issue");
    check("add_no_start_yet", {15'd0, rs_if.uf_start}, 16'd0);
    next_cycle();
    rs_if.issue_valid = 1'b0;
    probe();
    check_dispatch("add", 3'd1, 16'd5, 16'd3);
    check("add_inst", rs_if.uf_inst, 16'h1230);
    next_cycle();
    probe();
    check("add_single_pulse", {15'd0, rs_if.uf_start}, 16'd0);
    rs_if.uf_done = 1'b1; rs_if.uf_done_tag = 3'd1;
    next_cycle();
    rs_if.uf_done = 1'b0;
    probe();
    check("all_free_no_start", {15'd0, rs_if.uf_start}, 16'd0);

    // SUB waiting on tag 2, woken by CDB
    issue(16'h0451, 16'd0, 16'd7, 3'd2, 3'd0);
    next_cycle();
    rs_if.issue_valid = 1'b0;
    probe();
    $display("step sub_wakeup");
    check("sub_waiting_no_start", {15'd0, rs_if.uf_start}, 16'd0);
    rs_if.cdb_valid = 1'b1; rs_if.cdb_tag = 3'd2; rs_if.cdb_data = 16'd9;
    probe();
`ifdef RS_WAKEUP_BYPASS_EN
    check_dispatch("sub_bypass", 3'd1, 16'd9, 16'd7);
    next_cycle();
    rs_if.cdb_valid = 1'b0;
    probe();
    check("sub_after_bypass", {15'd0, rs_if.uf_start}, 16'd0);
`else
    check("sub_no_bypass", {15'd0, rs_if.uf_start}, 16'd0);
    next_cycle();
    rs_if.cdb_valid = 1'b0;
    probe();
    check_dispatch("sub_late", 3'd1, 16'd9, 16'd7);
`endif
    next_cycle();
    rs_if.uf_done = 1'b1; rs_if.uf_done_tag = 3'd1;
    rs_if.uf_available = 1'b0;
    next_cycle();
    rs_if.uf_done = 1'b0;

    // Fill all three entries with waiting ops
    $display("step fill");
    issue(16'h0002, 16'd0, 16'd11, 3'd5, 3'd0);
    next_cycle();
    issue(16'h0003, 16'd0, 16'd12, 3'd6, 3'd0);
    next_cycle();
    issue(16'h0004, 16'd0, 16'd13, 3'd7, 3'd0);
    next_cycle();
    issue(16'h00FF, 16'd1, 16'd1, 3'd0, 3'd0);
    probe();
    check("full_issue_ready", {15'd0, rs_if.issue_ready}, 16'd0);
    next_cycle();
    rs_if.issue_valid = 1'b0;
    rs_if.cdb_valid = 1'b1; rs_if.cdb_tag = 3'd5; rs_if.cdb_data = 16'h0021;
    next_cycle();
    rs_if.cdb_valid = 1'b0;
    rs_if.uf_available = 1'b1;
    probe();
    check_dispatch("fill_e0", 3'd1, 16'h0021, 16'd11);
    check("fill_e0_inst", rs_if.uf_inst, 16'h0002);
    next_cycle();
    rs_if.uf_available = 1'b0;
    rs_if.uf_done = 1'b1; rs_if.uf_done_tag = 3'd1;
    probe();
    check("done_ready_registered", {15'd0, rs_if.issue_ready}, 16'd0);
    next_cycle();
    rs_if.uf_done = 1'b0;
    probe();
    check("freed_issue_ready", {15'd0, rs_if.issue_ready}, 16'd1);
    issue(16'h0000, 16'd1, 16'd2, 3'd0, 3'd0);
    next_cycle();
    rs_if.issue_valid = 1'b0;
    rs_if.uf_available = 1'b1;
    probe();
    check("refill_issue_ready", {15'd0, rs_if.issue_ready}, 16'd0);
    check_dispatch("refill_e0", 3'd1, 16'd1, 16'd2);
    next_cycle();
    rs_if.uf_available = 1'b0;
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;

    // Two READY entries: lowest first, never back-to-back
    $display("step two_ready");
    issue(16'h0000, 16'h0010, 16'h0020, 3'd0, 3'd0);
    next_cycle();
    issue(16'h0001, 16'h0030, 16'h0040, 3'd0, 3'd0);
    next_cycle();
    rs_if.issue_valid = 1'b0;
    rs_if.uf_available = 1'b1;
    probe();
    check_dispatch("two_first", 3'd1, 16'h0010, 16'h0020);
    next_cycle();
    probe();
    check("two_gap", {15'd0, rs_if.uf_start}, 16'd0);
    next_cycle();
    probe();
    check_dispatch("two_second", 3'd2, 16'h0030, 16'h0040);
    next_cycle();
    probe();
    check("two_done", {15'd0, rs_if.uf_start}, 16'd0);
    rs_if.uf_available = 1'b0;
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;

    // Issue bypass: Qk=3 meets same-cycle CDB tag 3
    $display("step issue_bypass");
    issue(16'h0003, 16'd4, 16'd0, 3'd0, 3'd3);
    rs_if.cdb_valid = 1'b1; rs_if.cdb_tag = 3'd3; rs_if.cdb_data = 16'h00AA;
    next_cycle();
    rs_if.issue_valid = 1'b0;
    rs_if.cdb_valid = 1'b0;
    rs_if.uf_available = 1'b1;
    probe();
    check_dispatch("iss_byp", 3'd1, 16'd4, 16'h00AA);
    next_cycle();
    rs_if.uf_available = 1'b0;

    // Reset with entry 0 in EXEC and entry 1 READY
    $display("step reset_mid");
    issue(16'h0004, 16'd6, 16'd8, 3'd0, 3'd0);
    next_cycle();
    rs_if.issue_valid = 1'b0;
    reset = 1'b1;
    rs_if.uf_available = 1'b1;
    probe();
    check("rst_gates_start", {15'd0, rs_if.uf_start}, 16'd0);
    next_cycle();
    reset = 1'b0;
    probe();
    check("rst_mid_ready", {15'd0, rs_if.issue_ready}, 16'd1);
    check("rst_mid_start", {15'd0, rs_if.uf_start}, 16'd0);
    check("rst_mid_reg1",  rs_if.uf_reg1, 16'd0);
    check("rst_mid_tag",   {13'd0, rs_if.uf_tag}, 16'd0);
    rs_if.uf_done = 1'b1; rs_if.uf_done_tag = 3'd1;
    next_cycle();
    rs_if.uf_done = 1'b0;
    probe();
    check("stale_done_ready", {15'd0, rs_if.issue_ready}, 16'd1);
    check("stale_done_start", {15'd0, rs_if.uf_start}, 16'd0);
    issue(16'h0001, 16'h0101, 16'h0202, 3'd0, 3'd0);
    next_cycle();
    rs_if.issue_valid = 1'b0;
    probe();
    check_dispatch("post_rst", 3'd1, 16'h0101, 16'h0202);
    next_cycle();
    rs_if.uf_available = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
